// File: rtl/sodor_dmem_align.sv
`default_nettype none
// ============================================================================
// Module   : sodor_dmem_align
// Purpose  : Sub-word data-memory adapter between the Sodor core dmem port
//            and a word-only memory. Downstream traffic is always a
//            word-aligned word access. Load data is sign/zero-extended, and
//            sub-word stores are done as read-modify-write. Misaligned or
//            illegal requests and memory response timeouts are reported
//            through core_resp_err.
// Ports    : clk, rst_n          clock, synchronous active-low reset
//            core_req_*          request from core (valid/ready handshake)
//            core_resp_*         one-cycle response pulse with data/err
//            mem_req_*           word request to memory (write_en in WR only)
//            mem_resp_*          read data returned by memory
// Revision : 1.0  initial release
// ============================================================================
module sodor_dmem_align #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [DATA_W-1:0] core_req_addr,
  input  logic [DATA_W-1:0] core_req_data,
  input  logic              core_req_fcn,
  input  logic [2:0]        core_req_typ,
  output logic              core_resp_valid,
  output logic [DATA_W-1:0] core_resp_data,
  output logic              core_resp_err,
  output logic              mem_req_valid,
  output logic [DATA_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic              mem_req_write_en,
  output logic [2:0]        mem_req_typ,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);

  localparam logic [2:0] c_TYP_B  = 3'd1;
  localparam logic [2:0] c_TYP_H  = 3'd2;
  localparam logic [2:0] c_TYP_W  = 3'd3;
  localparam logic [2:0] c_TYP_BU = 3'd5;
  localparam logic [2:0] c_TYP_HU = 3'd6;

  localparam int                 c_CNT_W    = $clog2(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t              r_state;
  logic [1:0]          r_lane;       // byte offset of the request
  logic [15:0]         r_sdata;      // only the low half is ever merged
  logic                r_fcn;
  logic [2:0]          r_typ;
  logic [c_CNT_W-1:0]  r_cnt;        // cycles spent in RD

  logic                r_core_req_ready;
  logic                r_core_resp_valid;
  logic [DATA_W-1:0]   r_core_resp_data;
  logic                r_core_resp_err;
  logic                r_mem_req_valid;
  logic [DATA_W-1:0]   r_mem_req_addr;
  logic [DATA_W-1:0]   r_mem_req_data;
  logic                r_mem_req_write_en;

  logic                w_req_err;
  logic                w_is_word_st;
  logic [DATA_W-1:0]   w_shifted;
  logic [DATA_W-1:0]   w_load_ext;
  logic [DATA_W-1:0]   w_merge;

  assign core_req_ready   = r_core_req_ready;
  assign core_resp_valid  = r_core_resp_valid;
  assign core_resp_data   = r_core_resp_data;
  assign core_resp_err    = r_core_resp_err;
  assign mem_req_valid    = r_mem_req_valid;
  assign mem_req_addr     = r_mem_req_addr;
  assign mem_req_data     = r_mem_req_data;
  assign mem_req_write_en = r_mem_req_write_en;
  assign mem_req_typ      = c_TYP_W;

  // Alignment / legality check on the incoming request.
  always_comb begin
    w_req_err = 1'b0;
    case (core_req_typ)
      c_TYP_B, c_TYP_BU: w_req_err = 1'b0;
      c_TYP_H, c_TYP_HU: w_req_err = core_req_addr[0];
      c_TYP_W:           w_req_err = |core_req_addr[1:0];
      default:           w_req_err = 1'b1;
    endcase
  end

  // Full-word stores need no read; everything else goes through RD first.
  assign w_is_word_st = core_req_fcn && (core_req_typ == c_TYP_W);

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  assign w_shifted = mem_resp_data >> {r_lane, 3'b000};

  always_comb begin
    w_load_ext = w_shifted;
    case (r_typ)
      c_TYP_B:  w_load_ext = {{(DATA_W-8){w_shifted[7]}}, w_shifted[7:0]};
      c_TYP_BU: w_load_ext = {{(DATA_W-8){1'b0}}, w_shifted[7:0]};
      c_TYP_H:  w_load_ext = {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
      c_TYP_HU: w_load_ext = {{(DATA_W-16){1'b0}}, w_shifted[15:0]};
      default:  w_load_ext = w_shifted;  // word: lane is always 0
    endcase
  end

  // Read-modify-write merge: overwrite one lane of the word just read.
  always_comb begin
    w_merge = mem_resp_data;
    case (r_typ)
      c_TYP_B, c_TYP_BU: begin
        case (r_lane)
          2'd0:    w_merge[7:0]   = r_sdata[7:0];
          2'd1:    w_merge[15:8]  = r_sdata[7:0];
          2'd2:    w_merge[23:16] = r_sdata[7:0];
          default: w_merge[31:24] = r_sdata[7:0];
        endcase
      end
      c_TYP_H, c_TYP_HU: begin
        if (r_lane[1]) begin
          w_merge[31:16] = r_sdata;
        end else begin
          w_merge[15:0] = r_sdata;
        end
      end
      default: w_merge = mem_resp_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state            <= S_IDLE;
      r_lane             <= '0;
      r_sdata            <= '0;
      r_fcn              <= 1'b0;
      r_typ              <= '0;
      r_cnt              <= '0;
      r_core_req_ready   <= 1'b1;
      r_core_resp_valid  <= 1'b0;
      r_core_resp_data   <= '0;
      r_core_resp_err    <= 1'b0;
      r_mem_req_valid    <= 1'b0;
      r_mem_req_addr     <= '0;
      r_mem_req_data     <= '0;
      r_mem_req_write_en <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (core_req_valid) begin
            r_lane           <= core_req_addr[1:0];
            r_sdata          <= core_req_data[15:0];
            r_fcn            <= core_req_fcn;
            r_typ            <= core_req_typ;
            r_cnt            <= '0;
            r_core_req_ready <= 1'b0;
            if (w_req_err) begin
              r_state           <= S_RESP;
              r_core_resp_valid <= 1'b1;
              r_core_resp_err   <= 1'b1;
              r_core_resp_data  <= '0;
            end else begin
              r_mem_req_valid <= 1'b1;
              r_mem_req_addr  <= {core_req_addr[DATA_W-1:2], 2'b00};
              if (w_is_word_st) begin
                r_state            <= S_WR;
                r_mem_req_write_en <= 1'b1;
                r_mem_req_data     <= core_req_data;
              end else begin
                r_state <= S_RD;
              end
            end
          end
        end

        S_RD: begin
          if (mem_resp_valid) begin
            if (r_fcn) begin
              r_state            <= S_WR;
              r_mem_req_write_en <= 1'b1;
              r_mem_req_data     <= w_merge;
            end else begin
              r_state           <= S_RESP;
              r_mem_req_valid   <= 1'b0;
              r_mem_req_addr    <= '0;
              r_core_resp_valid <= 1'b1;
              r_core_resp_data  <= w_load_ext;
              r_core_resp_err   <= 1'b0;
            end
          end else if (r_cnt == c_CNT_LAST) begin
            // Memory never answered: give up, and never write for a store.
            r_state           <= S_RESP;
            r_mem_req_valid   <= 1'b0;
            r_mem_req_addr    <= '0;
            r_core_resp_valid <= 1'b1;
            r_core_resp_data  <= '0;
            r_core_resp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        S_WR: begin
          r_state            <= S_RESP;
          r_mem_req_valid    <= 1'b0;
          r_mem_req_write_en <= 1'b0;
          r_mem_req_addr     <= '0;
          r_mem_req_data     <= '0;
          r_core_resp_valid  <= 1'b1;
          r_core_resp_data   <= '0;
          r_core_resp_err    <= 1'b0;
        end

        S_RESP: begin
          r_state           <= S_IDLE;
          r_core_resp_valid <= 1'b0;
          r_core_resp_data  <= '0;
          r_core_resp_err   <= 1'b0;
          r_core_req_ready  <= 1'b1;
        end

        default: begin
          r_state          <= S_IDLE;
          r_core_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sodor_dmem_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_sodor_dmem_align
// Purpose  : Self-checking bench for sodor_dmem_align: directed vector table,
//            timeout and mid-transaction reset sequences, then randomized
//            transactions against a behavioural memory/adapter model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sodor_dmem_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req_valid;
  logic        core_req_ready;
  logic [31:0] core_req_addr;
  logic [31:0] core_req_data;
  logic        core_req_fcn;
  logic [2:0]  core_req_typ;
  logic        core_resp_valid;
  logic [31:0] core_resp_data;
  logic        core_resp_err;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_req_write_en;
  logic [2:0]  mem_req_typ;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  always #5 clk = ~clk;

  sodor_dmem_align #(.DATA_W(32), .TIMEOUT(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .core_req_valid   (core_req_valid),
    .core_req_ready   (core_req_ready),
    .core_req_addr    (core_req_addr),
    .core_req_data    (core_req_data),
    .core_req_fcn     (core_req_fcn),
    .core_req_typ     (core_req_typ),
    .core_resp_valid  (core_resp_valid),
    .core_resp_data   (core_resp_data),
    .core_resp_err    (core_resp_err),
    .mem_req_valid    (mem_req_valid),
    .mem_req_addr     (mem_req_addr),
    .mem_req_data     (mem_req_data),
    .mem_req_write_en (mem_req_write_en),
    .mem_req_typ      (mem_req_typ),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_data    (mem_resp_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- memory responder / write monitor ----------------
  logic [31:0] mem       [int unsigned];   // what the memory actually holds
  logic [31:0] model_mem [int unsigned];   // what the model says it should hold
  bit          resp_en   = 1'b1;
  bit          prev_req  = 1'b0;
  logic [31:0] prev_addr = '0;
  int          req_cnt   = 0;
  int          wr_cnt    = 0;
  logic [31:0] wr_addr   = '0;
  logic [31:0] wr_data   = '0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    int unsigned k;
    k = int'(a >> 2);
    if (mem.exists(k)) return mem[k];
    return 32'h0;
  endfunction

  // Answers a read one cycle after it is first seen; data is noise otherwise.
  always @(posedge clk) begin
    #2;
    mem_resp_valid = prev_req;
    mem_resp_data  = prev_req ? rd_word(prev_addr) : $urandom();
    prev_req       = resp_en && rst_n && mem_req_valid && !mem_req_write_en;
    prev_addr      = mem_req_addr;
    if (mem_req_valid) req_cnt++;
    if (mem_req_valid && mem_req_write_en) begin
      wr_cnt++;
      wr_addr = mem_req_addr;
      wr_data = mem_req_data;
      mem[int'(mem_req_addr >> 2)] = mem_req_data;
    end
  end

  // ---------------- behavioural reference model ----------------
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic f,
                       input logic [2:0] t, output logic [31:0] ed, output logic ee,
                       output int el, output logic ew, output logic [31:0] ewd);
    logic [31:0] w, sh, mask, ins;
    int unsigned k, ofs;
    k   = int'(a >> 2);
    ofs = int'(a & 32'd3);
    w   = model_mem.exists(k) ? model_mem[k] : 32'h0;
    ed = 32'h0; ee = 1'b0; el = 0; ew = 1'b0; ewd = 32'h0;
    if (t == 3'd0 || t == 3'd4 || t == 3'd7 ||
        ((t == 3'd2 || t == 3'd6) && (ofs % 2 != 0)) ||
        (t == 3'd3 && ofs != 0)) begin
      ee = 1'b1; el = 1;
    end else if (!f) begin
      el = 3;
      sh = w >> (8 * ofs);
      case (t)
        3'd1: ed = ((sh & 32'hFF) >= 32'h80) ? ((sh & 32'hFF) | 32'hFFFF_FF00) : (sh & 32'hFF);
        3'd5: ed = sh & 32'hFF;
        3'd2: ed = ((sh & 32'hFFFF) >= 32'h8000) ? ((sh & 32'hFFFF) | 32'hFFFF_0000) : (sh & 32'hFFFF);
        3'd6: ed = sh & 32'hFFFF;
        default: ed = w;
      endcase
    end else begin
      ew = 1'b1;
      if (t == 3'd3) begin
        el  = 2;
        ewd = d;
      end else begin
        el = 4;
        if (t == 3'd1 || t == 3'd5) begin
          mask = 32'hFF << (8 * ofs);
          ins  = (d & 32'hFF) << (8 * ofs);
        end else begin
          mask = 32'hFFFF << (16 * (ofs / 2));
          ins  = (d & 32'hFFFF) << (16 * (ofs / 2));
        end
        ewd = (w & ~mask) | ins;
      end
      model_mem[k] = ewd;
    end
  endtask

  // ---------------- one core transaction ----------------
  task automatic do_txn(input string nm, input logic [31:0] a, input logic [31:0] d,
                        input logic f, input logic [2:0] t, input logic [31:0] ed,
                        input logic ee, input int el, input logic ew, input logic [31:0] ewd);
    int lat, rq0, wr0;
    @(negedge clk);
    chk({nm, "/ready"}, {31'b0, core_req_ready}, 32'd1);
    core_req_valid = 1'b1;
    core_req_addr  = a;
    core_req_data  = d;
    core_req_fcn   = f;
    core_req_typ   = t;
    rq0 = req_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      core_req_valid = 1'b0;
      core_req_addr  = $urandom();
      lat++;
    end while (!core_resp_valid && lat < 40);
    chk({nm, "/resp_valid"}, {31'b0, core_resp_valid}, 32'd1);
    chk({nm, "/latency"}, 32'(lat), 32'(el));
    chk({nm, "/resp_data"}, core_resp_data, ed);
    chk({nm, "/resp_err"}, {31'b0, core_resp_err}, {31'b0, ee});
    chk({nm, "/mem_req_cycles"}, 32'(req_cnt - rq0), 32'(el - 1));
    chk({nm, "/writes"}, 32'(wr_cnt - wr0), {31'b0, ew});
    if (ew) begin
      chk({nm, "/wr_addr"}, wr_addr, a & 32'hFFFF_FFFC);
      chk({nm, "/wr_data"}, wr_data, ewd);
    end
    @(negedge clk);
    chk({nm, "/resp_pulse"}, {30'b0, core_resp_valid, core_req_ready}, 32'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fcn;
    logic [2:0]  typ;
    logic [31:0] mword;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    logic        exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vt[15];

  initial begin
    int ntx;
    logic [31:0] a, d, ed, ewd;
    logic f, ee, ew;
    logic [2:0] t;
    int el;

    vt[0]  = '{32'h103, 32'h0,         1'b0, 3'd1, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 3, 1'b0, 32'h0};
    vt[1]  = '{32'h102, 32'h0,         1'b0, 3'd6, 32'h80FF_1234, 32'h0000_80FF, 1'b0, 3, 1'b0, 32'h0};
    vt[2]  = '{32'h201, 32'hDEAD_BEAB, 1'b1, 3'd1, 32'h1122_3344, 32'h0,         1'b0, 4, 1'b1, 32'h1122_AB44};
    vt[3]  = '{32'h202, 32'h1234_5678, 1'b1, 3'd3, 32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0};
    vt[4]  = '{32'h104, 32'h0,         1'b0, 3'd3, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0, 3, 1'b0, 32'h0};
    vt[5]  = '{32'h106, 32'h0,         1'b0, 3'd2, 32'h8001_7FFF, 32'hFFFF_8001, 1'b0, 3, 1'b0, 32'h0};
    vt[6]  = '{32'h100, 32'h0,         1'b0, 3'd5, 32'h1234_56F0, 32'h0000_00F0, 1'b0, 3, 1'b0, 32'h0};
    vt[7]  = '{32'h302, 32'h1234_5678, 1'b1, 3'd2, 32'hAABB_CCDD, 32'h0,         1'b0, 4, 1'b1, 32'h5678_CCDD};
    vt[8]  = '{32'h304, 32'h0102_0304, 1'b1, 3'd3, 32'h0,         32'h0,         1'b0, 2, 1'b1, 32'h0102_0304};
    vt[9]  = '{32'h000, 32'h0,         1'b0, 3'd4, 32'h5555_5555, 32'h0,         1'b1, 1, 1'b0, 32'h0};
    vt[10] = '{32'h101, 32'h0,         1'b0, 3'd2, 32'h5555_5555, 32'h0,         1'b1, 1, 1'b0, 32'h0};
    vt[11] = '{32'h108, 32'hFFFF_FFFF, 1'b1, 3'd7, 32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0};
    vt[12] = '{32'h203, 32'h0000_0055, 1'b1, 3'd1, 32'h1122_3344, 32'h0,         1'b0, 4, 1'b1, 32'h5522_3344};
    vt[13] = '{32'h102, 32'h0,         1'b0, 3'd1, 32'h807F_0000, 32'h0000_007F, 1'b0, 3, 1'b0, 32'h0};
    vt[14] = '{32'h10C, 32'h0,         1'b0, 3'd0, 32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0};

    rst_n          = 1'b0;
    core_req_valid = 1'b0;
    core_req_addr  = '0;
    core_req_data  = '0;
    core_req_fcn   = 1'b0;
    core_req_typ   = '0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset/ready", {31'b0, core_req_ready}, 32'd1);
    chk("reset/resp_valid", {31'b0, core_resp_valid}, 32'd0);
    chk("reset/resp_err", {31'b0, core_resp_err}, 32'd0);
    chk("reset/resp_data", core_resp_data, 32'h0);
    chk("reset/mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("reset/mem_req_we", {31'b0, mem_req_write_en}, 32'd0);
    chk("reset/mem_req_addr", mem_req_addr, 32'h0);
    chk("reset/mem_req_data", mem_req_data, 32'h0);
    chk("reset/mem_req_typ", {29'b0, mem_req_typ}, 32'd3);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      mem[int'(vt[i].addr >> 2)]       = vt[i].mword;
      model_mem[int'(vt[i].addr >> 2)] = vt[i].mword;
      do_txn($sformatf("vec%0d", i), vt[i].addr, vt[i].data, vt[i].fcn, vt[i].typ,
             vt[i].exp_data, vt[i].exp_err, vt[i].exp_lat, vt[i].exp_wr, vt[i].exp_wdata);
    end

    // Timeouts: 16 RD cycles, then an error response; no write for a store.
    resp_en = 1'b0;
    do_txn("timeout_load", 32'h10, 32'h0, 1'b0, 3'd1, 32'h0, 1'b1, 17, 1'b0, 32'h0);
    do_txn("timeout_sb", 32'h11, 32'hAA, 1'b1, 3'd1, 32'h0, 1'b1, 17, 1'b0, 32'h0);
    resp_en = 1'b1;

    // Randomized traffic over a small shared address window
    for (int i = 0; i < 64; i++) begin
      logic [31:0] v;
      v = $urandom();
      mem[i]       = v;
      model_mem[i] = v;
    end
    for (ntx = 0; ntx < 80; ntx++) begin
      a = $urandom_range(0, 255);
      d = $urandom();
      f = 1'($urandom_range(0, 1));
      t = 3'($urandom_range(0, 7));
      model(a, d, f, t, ed, ee, el, ew, ewd);
      do_txn($sformatf("rnd%0d", ntx), a, d, f, t, ed, ee, el, ew, ewd);
    end

    // Reset while in WR abandons the store with no response.
    @(negedge clk);
    core_req_valid = 1'b1;
    core_req_addr  = 32'h40;
    core_req_data  = 32'h7777_8888;
    core_req_fcn   = 1'b1;
    core_req_typ   = 3'd3;
    @(posedge clk);
    @(negedge clk);
    core_req_valid = 1'b0;
    chk("rst_wr/in_wr", {30'b0, mem_req_valid, mem_req_write_en}, 32'd3);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wr/ready", {31'b0, core_req_ready}, 32'd1);
    chk("rst_wr/outputs", {28'b0, core_resp_valid, core_resp_err, mem_req_valid, mem_req_write_en}, 32'd0);
    chk("rst_wr/mem_req_addr", mem_req_addr, 32'h0);
    chk("rst_wr/mem_req_data", mem_req_data, 32'h0);
    chk("rst_wr/mem_req_typ", {29'b0, mem_req_typ}, 32'd3);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_wr/no_resp", {31'b0, core_resp_valid}, 32'd0);
    end
    mem[32'h50 >> 2] = 32'h0BAD_F00D;
    do_txn("post_reset_lw", 32'h50, 32'h0, 1'b0, 3'd3, 32'h0BAD_F00D, 1'b0, 3, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
